sa_tile_sched: RTL
==================

Name: sa_tile_sched

Overview:
- Tile sequencer for the weight-stationary systolic array and its column output controller.
- On start it runs one tile: preloads weights, streams activations with per-row skew, flushes the array, then hands results to the output controller.
- Drives buffer read strobes and addresses, per-row feed enables, the array fire pulse, and the drain handshake.
- Sits between the host/ESP command path and the array plus output-controller pair.

Parameters:
- ROWS, 8, array rows; also the number of weight-preload cycles.
- COLS, 8, array columns; also the number of flush cycles.
- KW, 8, width of the reduction-length field.
- AW, 10, buffer address width; must satisfy AW >= KW.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  begin tile; sampled only in IDLE
- abort  in  1  synchronous abort
- cfg_k  in  KW  reduction length K, latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at tile end
- err_zero_k  out  1  sticky; set when a start is accepted with K=0
- w_rd_en  out  1  weight buffer read strobe
- w_rd_addr  out  AW  weight buffer address
- a_rd_en  out  1  activation buffer read strobe
- a_rd_addr  out  AW  activation buffer address
- row_en  out  ROWS  skewed per-row activation-valid mask
- fire  out  1  one-cycle array fire pulse
- drain_req  out  1  request to output controller to capture results
- drain_ack  in  1  one-cycle completion pulse from output controller
- perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- All outputs are Moore, decoded from registered state and counters. All outputs reset to 0. State resets to IDLE.
- Cycle n means the cycle after clock edge n; start is sampled at edge 0.
- IDLE:
  - start=1 with cfg_k>0: latch K, clear err_zero_k, go to PRELOAD.
  - start=1 with cfg_k=0: set err_zero_k, go to DONE (no buffer reads, no fire).
- PRELOAD, ROWS cycles:
  - w_rd_en=1; w_rd_addr counts 0..ROWS-1.
  - Then go to STREAM.
- STREAM, K+ROWS-1 cycles, stream index t=0..K+ROWS-2:
  - a_rd_en=1 and a_rd_addr=t while t<K.
  - row_en[r]=1 iff r <= t < r+K.
  - Then go to FLUSH.
- FLUSH, COLS cycles:
  - fire=1 on the last FLUSH cycle only.
  - Then go to DRAIN.
- DRAIN:
  - drain_req held high until drain_ack is seen; then go to DONE.
  - drain_ack outside DRAIN is ignored.
- DONE, one cycle:
  - done=1, busy=1, then go to IDLE.
  - A start arriving in the DONE cycle is ignored.
- abort=1 in any non-IDLE state: go to IDLE at the next edge. All strobes, row_en and drain_req drop; no done pulse. abort has priority over drain_ack and over counter expiry.
- start while busy is ignored; cfg_k changes mid-tile have no effect.
- Counter widths: the stream counter is KW+clog2(ROWS)+1 bits, so K=2^KW-1 does not wrap. Address counters zero-extend to AW.
- Async reset mid-tile: immediate return to IDLE with all outputs 0. err_zero_k and perf_cycles are cleared.

Optional Feature:
- Macro: SA_TILE_PERF_EN.
- Defined: perf_cycles increments every cycle busy=1 and saturates at 2^32-1. It is cleared on an accepted start and holds its value while in IDLE.
- Undefined: no counter logic; perf_cycles is tied to 0.

Decomposition:
- sa_pkg holds:
  - the state enum typedef (IDLE, PRELOAD, STREAM, FLUSH, DRAIN, DONE);
  - the default ROWS/COLS/KW/AW localparams;
  - the perf counter width constant.
- Sub-module sa_skew_gen: from the stream index t and K, produces row_en[ROWS-1:0]. Purely combinational compare per row; the registered index stays in the parent.

Test Plan:
- ROWS=COLS=8, K=4, start at edge 0, drain_ack at cycle 30 ->
  - w_rd_en cycles 1-8, addr 0..7;
  - a_rd_en cycles 9-12, addr 0..3;
  - row_en[0] cycles 9-12, row_en[7] cycles 16-19;
  - fire only at cycle 27; drain_req cycles 28-30;
  - done at cycle 31; busy cycles 1-31.
- K=0 start -> DONE at cycle 1, done=1, err_zero_k=1, no w_rd_en/a_rd_en/fire. A following start with K=1 clears err_zero_k.
- abort asserted at cycle 12 (in STREAM) -> cycle 13 is IDLE: busy=0, a_rd_en=0, row_en=0, no fire, no done.
- start pulsed at cycle 5 and at cycle 31 (DONE), K=2 -> both ignored. Exactly one done pulse; cfg_k changed to 9 at cycle 5 has no effect (a_rd_en lasts exactly 2 cycles).
- rstn deasserted asynchronously mid-DRAIN -> all outputs 0 immediately. Held drain_ack afterwards produces no done.
- SA_TILE_PERF_EN defined, K=4 run as in the first test -> perf_cycles=31 in IDLE afterwards. Undefined -> perf_cycles stays 0.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding and default sizes for the systolic tile sequencer
package sa_pkg;
    typedef enum logic [2:0] {IDLE, PRELOAD, STREAM, FLUSH, DRAIN, DONE} sa_state_e;
    localparam int SA_ROWS   = 8;
    localparam int SA_COLS   = 8;
    localparam int SA_KW     = 8;
    localparam int SA_AW     = 10;
    localparam int SA_PERF_W = 32;
endpackage

// File: rtl/sa_skew_gen.sv
// sa_skew_gen: per-row activation-valid mask, row r live while r <= t < r+K
module sa_skew_gen #(
    parameter int ROWS = 8,
    parameter int KW   = 8,
    parameter int TW   = 12
) (
    input  logic            en,
    input  logic [TW-1:0]   t,
    input  logic [KW-1:0]   k,
    output logic [ROWS-1:0] row_en
);
    genvar r;
    generate
        for (r = 0; r < ROWS; r++) begin : g_row
            assign row_en[r] = en && (t >= TW'(r)) && (t < TW'(r) + TW'(k));
        end
    endgenerate
endmodule

// File: rtl/sa_tile_sched.sv
// sa_tile_sched: one-tile sequencer (preload, skewed stream, flush, drain) for the systolic array
// Build option SA_TILE_PERF_EN enables the saturating busy-cycle counter on perf_cycles.
module sa_tile_sched
    import sa_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS,
    parameter int KW   = SA_KW,
    parameter int AW   = SA_AW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    input  logic [KW-1:0]   cfg_k,
    output logic            busy,
    output logic            done,
    output logic            err_zero_k,
    output logic            w_rd_en,
    output logic [AW-1:0]   w_rd_addr,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_rd_addr,
    output logic [ROWS-1:0] row_en,
    output logic            fire,
    output logic            drain_req,
    input  logic            drain_ack,
    output logic [31:0]     perf_cycles
);
    localparam int TW = KW + $clog2(ROWS) + 1;

    sa_state_e     state, state_n;
    logic [TW-1:0] cnt;
    logic [KW-1:0] k_q;
    logic          accept;
    logic          t_last;

    assign accept = (state == IDLE) && start;
    // Last stream index is K+ROWS-2; K is never 0 here so the modular sum is exact.
    assign t_last = cnt == TW'(k_q) + TW'(ROWS) - TW'(2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state != IDLE && abort) state_n = IDLE;
        else
            case (state)
                IDLE:    if (start) state_n = (cfg_k == '0) ? DONE : PRELOAD;
                PRELOAD: if (cnt == TW'(ROWS - 1)) state_n = STREAM;
                STREAM:  if (t_last) state_n = FLUSH;
                FLUSH:   if (cnt == TW'(COLS - 1)) state_n = DRAIN;
                DRAIN:   if (drain_ack) state_n = DONE;
                default: state_n = IDLE;
            endcase
    end

    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        w_rd_en   = state == PRELOAD;
        w_rd_addr = w_rd_en ? AW'(cnt) : '0;
        a_rd_en   = (state == STREAM) && (cnt < TW'(k_q));
        a_rd_addr = a_rd_en ? AW'(cnt) : '0;
        fire      = (state == FLUSH) && (cnt == TW'(COLS - 1));
        drain_req = state == DRAIN;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            k_q        <= '0;
            err_zero_k <= 1'b0;
        end else begin
            cnt        <= (state == IDLE || state_n != state) ? '0 : cnt + 1'b1;
            k_q        <= accept ? cfg_k : k_q;
            err_zero_k <= accept ? (cfg_k == '0) : err_zero_k;
        end
    end

    sa_skew_gen #(.ROWS(ROWS), .KW(KW), .TW(TW)) u_skew (
        .en     (state == STREAM),
        .t      (cnt),
        .k      (k_q),
        .row_en (row_en)
    );

`ifdef SA_TILE_PERF_EN
    logic [SA_PERF_W-1:0] perf_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                    perf_q <= '0;
        else if (accept)              perf_q <= '0;
        else if (busy && perf_q != '1) perf_q <= perf_q + 1'b1;
    end
    assign perf_cycles = 32'(perf_q);
`else
    assign perf_cycles = '0;
`endif
endmodule
